dm_dump_ctrl: RTL

Debug read-out stage that sits directly downstream of the data-memory RAM. After the processor halts, it walks the data memory from address 0 to MEM_SIZE-1. It drives the RAM's address and read-enable inputs, consumes the RAM's read data, and serializes each word MSB-byte-first onto the UART transmitter's byte interface. It is the data-memory half of the debug unit's "dump state to host" sequence.

---
 rtl/dm_dump_pkg.sv | 32 +++
 rtl/dm_dump_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dm_dump_pkg.sv
// Shared constants and state encoding for the data-memory dump controller.
// Optional checksum trailer is enabled by defining DM_DUMP_CHKSUM_EN.
package dm_dump_pkg;

  localparam int unsigned DM_MEM_SIZE    = 9;
  localparam int unsigned DM_ADDR_LENGTH = 11;
  localparam int unsigned DM_DATA_LENGTH = 16;
  localparam int unsigned DM_BYTE_WIDTH  = 8;
  localparam int unsigned DM_NBYTES      = DM_DATA_LENGTH / DM_BYTE_WIDTH;
  localparam int unsigned DM_CHK_W       = DM_BYTE_WIDTH;

  // Byte-index counter width; at least one bit even for single-byte words.
  function automatic int unsigned bidx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
`ifdef DM_DUMP_CHKSUM_EN
    ,
    ST_CHK,
    ST_CHK_WAIT
`endif
  } state_e;

endpackage

// File: rtl/dm_dump_ctrl.sv
// Data-memory dump controller: after a start request, reads every data-memory
// word (address 0..MEM_SIZE-1) and sends it MSB byte first to the UART TX.
// Ports:
//   i_clock, i_reset (sync, active-low)  clock / reset
//   i_start                               dump request, sampled in IDLE only
//   i_Data                                RAM read data (1-cycle latency)
//   i_tx_done                             UART TX byte-finished pulse
//   o_Addr, o_Rd                          RAM address / read enable
//   o_tx_data, o_tx_start                 UART TX byte and load pulse
//   o_busy, o_done                        activity flag / end-of-dump pulse
// Define DM_DUMP_CHKSUM_EN to append an XOR checksum byte after the data.
module dm_dump_ctrl
  import dm_dump_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = DM_MEM_SIZE,
  parameter int unsigned ADDR_LENGTH = DM_ADDR_LENGTH,
  parameter int unsigned DATA_LENGTH = DM_DATA_LENGTH,
  parameter int unsigned BYTE_WIDTH  = DM_BYTE_WIDTH
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [DATA_LENGTH-1:0] i_Data,
  input  logic                   i_tx_done,
  output logic [ADDR_LENGTH-1:0] o_Addr,
  output logic                   o_Rd,
  output logic [BYTE_WIDTH-1:0]  o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned NBYTES = DATA_LENGTH / 8;
  localparam int unsigned BIDX_W = bidx_width(NBYTES);
  localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(MEM_SIZE - 1);
  localparam logic [BIDX_W-1:0]      LAST_BYTE = BIDX_W'(NBYTES - 1);

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] addr_d;
  logic [BIDX_W-1:0]      bidx_q, bidx_d;
  logic [DATA_LENGTH-1:0] word_q, word_d;
  logic [BYTE_WIDTH-1:0]  tx_data_d, send_byte;
  logic [BIDX_W+2:0]      shamt;
  logic                   rd_d, tx_start_d, busy_d, done_d;
`ifdef DM_DUMP_CHKSUM_EN
  logic [DM_CHK_W-1:0]    chk_q, chk_d;
`endif

  // Byte selected for the next SEND, MSB first.
  assign shamt     = {LAST_BYTE - bidx_d, 3'b000};
  assign send_byte = BYTE_WIDTH'(word_q >> shamt);

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d   = state_q;
    addr_d    = o_Addr;
    bidx_d    = bidx_q;
    word_d    = word_q;
    tx_data_d = o_tx_data;
`ifdef DM_DUMP_CHKSUM_EN
    chk_d     = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_READ;
          addr_d  = '0;
          bidx_d  = '0;
`ifdef DM_DUMP_CHKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      // RAM data is valid at the edge leaving READ and is zeroed once o_Rd
      // drops, so the word is captured on the READ->LATCH transition.
      ST_READ: begin
        state_d = ST_LATCH;
        word_d  = i_Data;
      end
      ST_LATCH: state_d = ST_SEND;
      ST_SEND:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (bidx_q != LAST_BYTE) begin
            bidx_d  = bidx_q + BIDX_W'(1);
            state_d = ST_SEND;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        bidx_d = '0;
        if (o_Addr == LAST_ADDR) begin
`ifdef DM_DUMP_CHKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_FIN;
`endif
        end else begin
          addr_d  = o_Addr + ADDR_LENGTH'(1);
          state_d = ST_READ;
        end
      end
`ifdef DM_DUMP_CHKSUM_EN
      ST_CHK: state_d = ST_CHK_WAIT;
      ST_CHK_WAIT: begin
        if (i_tx_done) state_d = ST_FIN;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_d       = (state_d == ST_READ);
    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FIN);

    if (state_d == ST_SEND) begin
      tx_data_d = send_byte;
`ifdef DM_DUMP_CHKSUM_EN
      chk_d     = chk_q ^ send_byte;
`endif
    end
`ifdef DM_DUMP_CHKSUM_EN
    if (state_d == ST_CHK) begin
      tx_data_d  = chk_q;
      tx_start_d = 1'b1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      o_Addr     <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      o_tx_data  <= '0;
      o_Rd       <= 1'b0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef DM_DUMP_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      o_Addr     <= addr_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      o_tx_data  <= tx_data_d;
      o_Rd       <= rd_d;
      o_tx_start <= tx_start_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
`ifdef DM_DUMP_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

endmodule
